// File: rtl/miriscv_mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states and
// transaction owner.
package miriscv_mem_arb_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } arb_state_e;

    typedef enum logic {
        OwnerInstr = 1'b0,
        OwnerData  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/miriscv_mem_arbiter_if.sv
// Bundle of fetch, LSU and shared memory port signals around the arbiter.
// The slave modport is the arbiter's view; master is the core+memory side.
interface miriscv_mem_arbiter_if
    import miriscv_mem_arb_pkg::*;
#(
    parameter int unsigned XLEN = miriscv_mem_arb_pkg::XLEN
) ();

    logic              instr_req_i;
    logic [XLEN-1:0]   instr_addr_i;
    logic              instr_rvalid_o;
    logic [XLEN-1:0]   instr_rdata_o;

    logic              data_req_i;
    logic              data_we_i;
    logic [XLEN/8-1:0] data_be_i;
    logic [XLEN-1:0]   data_addr_i;
    logic [XLEN-1:0]   data_wdata_i;
    logic              data_rvalid_o;
    logic [XLEN-1:0]   data_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;

    logic              err_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rvalid_i, mem_rdata_i,
        output err_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rvalid_i, mem_rdata_i,
        input  err_o
    );

endinterface

// File: rtl/miriscv_rr_arbiter2.sv
// Two-way round-robin picker: bit 0 = fetch, bit 1 = LSU. On a tie the
// requester that did not win last time is granted.
module miriscv_rr_arbiter2
    import miriscv_mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_owner_e last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_grant_i == OwnerInstr) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Arbitrates fetch and LSU requests onto a single memory port with one
// transaction outstanding, a WAIT timeout and a sticky protocol error flag.
module miriscv_mem_arbiter
    import miriscv_mem_arb_pkg::*;
#(
    parameter int unsigned XLEN    = miriscv_mem_arb_pkg::XLEN,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    miriscv_mem_arbiter_if.slave  bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    arb_owner_e        last_grant_q, last_grant_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN/8-1:0] mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

    logic [1:0]        req, gnt;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_data;

    assign req = {bus.data_req_i, bus.instr_req_i};

    miriscv_rr_arbiter2 u_rr (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid   = 1'b0;
        resp_data    = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.mem_rvalid_i) begin
                    err_d = 1'b1;
                end
                if (gnt[1]) begin
                    owner_d      = OwnerData;
                    last_grant_d = OwnerData;
                    mem_req_d    = 1'b1;
                    mem_we_d     = bus.data_we_i;
                    mem_be_d     = bus.data_be_i;
                    mem_addr_d   = bus.data_addr_i;
                    mem_wdata_d  = bus.data_wdata_i;
                    state_d      = StIssue;
                end else if (gnt[0]) begin
                    owner_d      = OwnerInstr;
                    last_grant_d = OwnerInstr;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '1;
                    mem_addr_d   = bus.instr_addr_i;
                    mem_wdata_d  = '0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (bus.mem_rvalid_i) begin
                    err_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A response arriving on the timeout cycle still counts as normal.
                if (bus.mem_rvalid_i) begin
                    resp_valid = 1'b1;
                    resp_data  = bus.mem_rdata_i;
                    state_d    = StIdle;
                end else if (cnt_q == CntW'(TIMEOUT)) begin
                    resp_valid = 1'b1;
                    err_d      = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A transaction abandoned by reset must never be answered.
        if (rst_i) begin
            resp_valid = 1'b0;
            resp_data  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            owner_q      <= OwnerInstr;
            last_grant_q <= OwnerInstr;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.instr_rvalid_o = resp_valid & (owner_q == OwnerInstr);
    assign bus.data_rvalid_o  = resp_valid & (owner_q == OwnerData);
    assign bus.instr_rdata_o  = bus.instr_rvalid_o ? resp_data : '0;
    assign bus.data_rdata_o   = bus.data_rvalid_o ? resp_data : '0;

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_be_o    = mem_be_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.err_o       = err_q;

endmodule
